demux4_stream: RTL and testbench
================================

DEMUX4_STREAM -- requirements
Module: demux4_stream

Interface
REQ-001 Parameter N, default 32, SHALL set the payload width in bits.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-004 in_data  input  N  SHALL be the payload offered by the upstream source.
REQ-005 in_sel  input  2  SHALL give the destination channel (0..3) of in_data.
REQ-006 in_valid  input  1  SHALL mark in_data/in_sel as valid.
REQ-007 in_ready  output  1  SHALL indicate the block accepts the offered beat this cycle.
REQ-008 out_data  output  4*N  SHALL carry channel k payload in bits [k*N +: N].
REQ-009 out_valid  output  4  SHALL mark bit k when channel k holds a valid beat.
REQ-010 out_ready  input  4  SHALL be bit k asserted when the channel k sink accepts.
REQ-011 idle  output  1  SHALL be high when out_valid == 4'b0000.

Function
REQ-012 Each channel k SHALL own one holding register (data + valid); out_data/out_valid SHALL be driven directly from these registers.
REQ-013 in_ready SHALL equal (!out_valid[in_sel] || out_ready[in_sel]), combinational, and SHALL NOT depend on in_valid.
REQ-014 An input transfer occurs when in_valid && in_ready; on that edge channel in_sel SHALL load in_data and set out_valid[in_sel].
REQ-015 An output transfer on channel k occurs when out_valid[k] && out_ready[k]; on that edge out_valid[k] SHALL clear unless the same edge loads channel k.
REQ-016 Simultaneous output transfer and reload on channel k SHALL keep out_valid[k]=1 with the new data (full throughput, one beat/cycle/channel).
REQ-017 Latency from accepted input to out_valid SHALL be exactly 1 cycle.
REQ-018 While out_valid[k] && !out_ready[k], channel k data SHALL remain stable.
REQ-019 Channels SHALL be independent: a stalled channel blocks only beats whose in_sel targets it; beats for other channels are accepted.
REQ-020 Beats SHALL leave each channel in acceptance order; no beat is dropped or duplicated.
REQ-021 Channels not selected, or with in_valid low, SHALL not change except by their own output transfer.
REQ-022 in_sel and in_data SHALL be ignored when in_valid is low.
REQ-023 out_data for a channel with out_valid=0 SHALL hold its last loaded value (or 0 after reset).

Reset
REQ-024 While rst_n=0, out_valid SHALL be 4'b0000, out_data all zero, idle=1, asynchronously.
REQ-025 Reset asserted mid-operation SHALL discard all held beats; no out_valid SHALL assert until an input transfer after rst_n deasserts.
REQ-026 in_ready SHALL be 1 during and immediately after reset (all channels empty).

Verification
REQ-027 Reset, then in_data=32'hA5A5_0001, in_sel=2, in_valid=1 one cycle, out_ready=0 -> next cycle out_valid=4'b0100, out_data[95:64]=32'hA5A5_0001, idle=0.
REQ-028 Channel 2 full, out_ready[2]=0, offer in_sel=2 -> in_ready=0, data held; then out_ready[2]=1 -> in_ready=1, new beat loaded same edge, out_valid[2] stays 1.
REQ-029 Channel 0 stalled full; offer beats to channels 1,3 on consecutive cycles -> both accepted, out_valid=4'b1011.
REQ-030 out_ready=4'b1111, stream 8 beats to channel 3 back-to-back (values 1..8) -> in_ready constantly 1, channel 3 emits 1..8 in order, one per cycle, 1-cycle latency.
REQ-031 All four channels full, assert rst_n=0 mid-cycle -> out_valid=0 and out_data=0 immediately, idle=1; after release no output until a new accepted beat.
REQ-032 in_valid=0 with in_sel toggling and random in_data for 10 cycles -> no channel state changes.

Source files
------------

// File: rtl/demux4_stream.sv
// Four-way stream demultiplexer: each beat is routed by in_sel to a per-channel
// one-deep holding register that drives that channel's output directly.
module demux4_stream #(
    parameter int N = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     in_data,
    input  logic [1:0]       in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [4*N-1:0]   out_data,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic             idle
);

    logic [3:0] load;

    // A full channel still accepts when its sink drains on the same edge.
    assign in_ready = !out_valid[in_sel] || out_ready[in_sel];
    assign idle     = (out_valid == 4'b0000);

    always_comb begin
        load = 4'b0000;
        if (in_valid && in_ready) begin
            load[in_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 4'b0000;
            out_data  <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (load[k]) begin
                    out_data[k*N +: N] <= in_data;
                    out_valid[k]       <= 1'b1;
                end else if (out_ready[k]) begin
                    out_valid[k] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_demux4_stream.sv
// Directed plus randomized bench for demux4_stream with a scoreboard of
// accepted beats, checked against what each channel emits.
module tb_demux4_stream;

    localparam int N = 32;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   in_data;
    logic [1:0]     in_sel;
    logic           in_valid;
    logic           in_ready;
    logic [4*N-1:0] out_data;
    logic [3:0]     out_valid;
    logic [3:0]     out_ready;
    logic           idle;

    demux4_stream #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .idle      (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int           ch;
        logic [N-1:0] data;
    } beat_t;

    beat_t        sb[$];
    logic [N-1:0] mdata [4];
    int           tests = 0;
    int           fails = 0;
    int           delivered [4];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int find_ch(input int ch);
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].ch == ch) return i;
        end
        return -1;
    endfunction

    function automatic logic [3:0] model_valid();
        logic [3:0] v;
        for (int k = 0; k < 4; k++) v[k] = (find_ch(k) >= 0);
        return v;
    endfunction

    // One clock cycle: drive at the falling edge, check after settling, then
    // retire/accept beats in the model for the coming rising edge.
    task automatic cycle(input logic [1:0] sel, input logic [N-1:0] data,
                         input logic v, input logic [3:0] rdy);
        logic [3:0] ev;
        logic       er;
        int         idx;
        @(negedge clk);
        in_sel    = sel;
        in_data   = data;
        in_valid  = v;
        out_ready = rdy;
        #1;
        ev = model_valid();
        er = !ev[sel] || rdy[sel];
        chk("in_ready", in_ready, er);
        chk("out_valid", out_valid, ev);
        chk("idle", idle, (ev == 4'b0000));
        chk("out_data", out_data, {mdata[3], mdata[2], mdata[1], mdata[0]});
        for (int k = 0; k < 4; k++) begin
            if (ev[k] && rdy[k]) begin
                idx = find_ch(k);
                chk($sformatf("ch%0d_order", k), out_data[k*N +: N], sb[idx].data);
                sb.delete(idx);
                delivered[k]++;
            end
        end
        if (v && er) begin
            sb.push_back('{ch: int'(sel), data: data});
            mdata[sel] = data;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_data   = '0;
        in_sel    = 2'd0;
        in_valid  = 1'b0;
        out_ready = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            mdata[k]     = '0;
            delivered[k] = 0;
        end

        #3;
        chk("rst_out_valid", out_valid, 4'b0000);
        chk("rst_out_data", out_data, 128'd0);
        chk("rst_idle", idle, 1'b1);
        chk("rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Single beat to channel 2 with sink stalled
        cycle(2'd2, 32'hA5A5_0001, 1'b1, 4'b0000);
        cycle(2'd0, 32'h0, 1'b0, 4'b0000);
        chk("first_valid", out_valid, 4'b0100);
        chk("first_data", out_data[95:64], 32'hA5A5_0001);
        chk("first_idle", idle, 1'b0);

        // Channel 2 full and stalled, then drain and reload on the same edge
        cycle(2'd2, 32'hBEEF_0002, 1'b1, 4'b0000);
        chk("stall_data", out_data[95:64], 32'hA5A5_0001);
        cycle(2'd2, 32'hBEEF_0003, 1'b1, 4'b0100);
        cycle(2'd0, 32'h0, 1'b0, 4'b0000);
        chk("reload_valid", out_valid[2], 1'b1);
        chk("reload_data", out_data[95:64], 32'hBEEF_0003);

        // Drain ch2, stall ch0, other channels still accept
        cycle(2'd0, 32'h0, 1'b0, 4'b0100);
        cycle(2'd0, 32'h0000_0010, 1'b1, 4'b0000);
        cycle(2'd1, 32'h0000_0011, 1'b1, 4'b0000);
        cycle(2'd3, 32'h0000_0013, 1'b1, 4'b0000);
        cycle(2'd0, 32'h0000_0099, 1'b1, 4'b0000);
        chk("indep_valid", out_valid, 4'b1011);

        // in_valid low: sel/data must be ignored
        for (int i = 0; i < 10; i++) begin
            cycle(2'(i), $urandom, 1'b0, 4'b0000);
        end
        chk("ignore_valid", out_valid, 4'b1011);

        // Back-to-back stream into channel 3 with all sinks ready
        cycle(2'd0, 32'h0, 1'b0, 4'b1111);
        delivered[3] = 0;
        for (int i = 1; i <= 8; i++) begin
            cycle(2'd3, 32'(i), 1'b1, 4'b1111);
        end
        cycle(2'd0, 32'h0, 1'b0, 4'b1111);
        cycle(2'd0, 32'h0, 1'b0, 4'b1111);
        chk("stream_count", 128'(delivered[3]), 128'd8);

        // Mixed random traffic
        for (int i = 0; i < 60; i++) begin
            cycle(2'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)));
        end

        // Fill all four, then reset mid-cycle
        for (int i = 0; i < 4; i++) begin
            cycle(2'(i), 32'hC0DE_0000 + 32'(i), 1'b1, 4'b0000);
        end
        cycle(2'd0, 32'h0, 1'b0, 4'b0000);
        chk("full_valid", out_valid, 4'b1111);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 4'b0000);
        chk("midrst_data", out_data, 128'd0);
        chk("midrst_idle", idle, 1'b1);
        chk("midrst_in_ready", in_ready, 1'b1);
        sb.delete();
        for (int k = 0; k < 4; k++) mdata[k] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(2'(i), 32'h0, 1'b0, 4'b0000);
        end
        chk("postrst_valid", out_valid, 4'b0000);
        cycle(2'd1, 32'h1234_5678, 1'b1, 4'b0000);
        cycle(2'd0, 32'h0, 1'b0, 4'b0010);
        cycle(2'd0, 32'h0, 1'b0, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
